// File: rtl/inversor_pkg.sv
// Shared types for the parametrised inverter: transform selector and
// occupancy states of the two-entry output buffer.
package inversor_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_NOT  = 2'b01,
    MODE_NEG  = 2'b10,
    MODE_ABS  = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } occ_t;

endpackage

// File: rtl/inversor_lane.sv
// One lane of the transform: combinational PASS / NOT / NEG / ABS with an
// overflow flag for the unrepresentable negation of the most negative value.
module inversor_lane
  import inversor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  mode_t            mode,
  input  logic             en,
  output logic [WIDTH-1:0] y_i,
  output logic             ovf_i
);

  localparam logic [WIDTH-1:0] ONE_V = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] neg;
  logic             is_min;

  assign neg    = (~a_i) + ONE_V;
  assign is_min = (a_i == MIN_V);

  // Negating MIN_V wraps back to MIN_V, so y already equals a in that case.
  always_comb begin
    y_i   = a_i;
    ovf_i = 1'b0;
    if (en) begin
      unique case (mode)
        MODE_NOT: y_i = ~a_i;
        MODE_NEG: begin
          y_i   = neg;
          ovf_i = is_min;
        end
        MODE_ABS: begin
          if (a_i[WIDTH-1]) y_i = neg;
          ovf_i = is_min;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/inversor_param.sv
// Registered multi-lane inverter on a valid/ready stream with a two-entry
// output buffer, per-lane overflow flags and a saturating transfer counter.
module inversor_param
  import inversor_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int CHANNELS  = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH*CHANNELS-1:0] a,
  input  logic [1:0]                mode,
  input  logic [CHANNELS-1:0]       mask,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH*CHANNELS-1:0] y,
  output logic [CHANNELS-1:0]       ovf,
  output logic [CNT_WIDTH-1:0]      count
);

  localparam int DW = WIDTH * CHANNELS;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  occ_t                 state_q, state_d;
  logic [DW-1:0]        head_y_q, head_y_d, tail_y_q, tail_y_d;
  logic [CHANNELS-1:0]  head_ovf_q, head_ovf_d, tail_ovf_q, tail_ovf_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic [DW-1:0]       new_y;
  logic [CHANNELS-1:0] new_ovf;
  mode_t               mode_s;
  logic                push, pop;

  assign mode_s = mode_t'(mode);

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
      inversor_lane #(.WIDTH(WIDTH)) u_lane (
        .a_i   (a[gi*WIDTH +: WIDTH]),
        .mode  (mode_s),
        .en    (mask[gi]),
        .y_i   (new_y[gi*WIDTH +: WIDTH]),
        .ovf_i (new_ovf[gi])
      );
    end
  endgenerate

  // in_ready depends only on registered state (and rst), never on out_ready.
  assign in_ready  = (state_q != FULL) & ~rst;
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign y     = out_valid ? head_y_q : '0;
  assign ovf   = out_valid ? head_ovf_q : '0;
  assign count = count_q;

  always_comb begin
    state_d    = state_q;
    head_y_d   = head_y_q;
    head_ovf_d = head_ovf_q;
    tail_y_d   = tail_y_q;
    tail_ovf_d = tail_ovf_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          head_y_d   = new_y;
          head_ovf_d = new_ovf;
          state_d    = ONE;
        end
      end
      ONE: begin
        unique case ({push, pop})
          2'b10: begin
            tail_y_d   = new_y;
            tail_ovf_d = new_ovf;
            state_d    = FULL;
          end
          2'b01: state_d = EMPTY;
          2'b11: begin
            head_y_d   = new_y;
            head_ovf_d = new_ovf;
          end
          default: ;
        endcase
      end
      FULL: begin
        if (pop) begin
          head_y_d   = tail_y_q;
          head_ovf_d = tail_ovf_q;
          state_d    = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (pop && (count_q != CNT_MAX)) count_d = count_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      head_y_q   <= '0;
      head_ovf_q <= '0;
      tail_y_q   <= '0;
      tail_ovf_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      head_y_q   <= head_y_d;
      head_ovf_q <= head_ovf_d;
      tail_y_q   <= tail_y_d;
      tail_ovf_q <= tail_ovf_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: doc/inversor_param.md
# inversor_param

Parametrised, registered successor to the combinational 4-bit inverter. It applies a per-word selectable transform to CHANNELS independent lanes of WIDTH bits each: pass, bitwise NOT, two's-complement negate, or absolute value. A per-channel mask selects which lanes are transformed. It sits on a valid/ready stream with a 2-entry output buffer, flags overflow per lane, and counts completed transfers.

## Interface
- WIDTH, 4, bits per lane; must be at least 2.
- CHANNELS, 1, number of lanes; must be at least 1.
- CNT_WIDTH, 16, width of the transfer counter.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept a word this cycle.
- a  in  WIDTH*CHANNELS  input word; lane i is a[i*WIDTH +: WIDTH].
- mode  in  2  transform, sampled with a: 00 PASS, 01 NOT, 10 NEG, 11 ABS.
- mask  in  CHANNELS  lane i is transformed only if mask[i]=1; sampled with a.
- out_valid  out  1  head entry present on y.
- out_ready  in  1  consumer accepts y this cycle.
- y  out  WIDTH*CHANNELS  transformed word, same lane packing as a.
- ovf  out  CHANNELS  per-lane overflow flag travelling with y.
- count  out  CNT_WIDTH  number of completed output transfers; saturating.

## Operation
- Input transfer: in_valid & in_ready at a rising edge. Output transfer: out_valid & out_ready at a rising edge.
- Per-lane transform, computed at input transfer and stored in the buffer:
  - Lane with mask[i]=0, or mode PASS: y_i = a_i, ovf_i = 0.
  - NOT: y_i = ~a_i, ovf_i = 0.
  - NEG: y_i = (~a_i + 1) mod 2^WIDTH.
  - ABS: y_i = a_i if a_i[WIDTH-1]=0, else the NEG result.
  - NEG and ABS set ovf_i = 1 only when a_i = 1 followed by WIDTH-1 zeros. In that case y_i = a_i.
- Buffer: 2-entry FIFO of {y, ovf}. Order is preserved; no word is dropped or duplicated.
- Occupancy FSM has three states: EMPTY, ONE, FULL.
  - EMPTY goes to ONE on push.
  - ONE goes to FULL on push without pop, and to EMPTY on pop without push. It stays in ONE on simultaneous push and pop.
  - FULL goes to ONE on pop. Push is impossible in FULL.
- in_ready = (state != FULL) & ~rst. It is a function of registered state only and has no combinational path from out_ready.
- out_valid = (state != EMPTY).
- y and ovf show the head entry and are forced to 0 when state is EMPTY.
- count increments by 1 per output transfer and holds at 2^CNT_WIDTH-1.
- mode and mask are ignored on cycles without an input transfer.

## Timing
- Reset (rst=1 at an edge):
  - Buffer cleared and state goes to EMPTY; buffered words are discarded and not counted.
  - out_valid=0, y=0, ovf=0, count=0.
  - in_ready=0 while rst=1, and 1 in the first cycle after rst falls.
- Reset asserted mid-operation overrides any simultaneous push or pop.
- Latency: a word accepted at edge k is on y with out_valid=1 in the cycle after edge k. This holds whether the buffer was EMPTY, or in ONE with a simultaneous pop.
- Throughput: 1 word/cycle sustained while out_ready=1.
- With out_ready=0, two words are accepted, then in_ready=0.
- After out_ready rises again, in_ready returns to 1 in the cycle after the first pop.
- count updates at the edge of the output transfer and is visible in the next cycle.
- out_valid must not fall without an output transfer. y must be stable while out_valid=1 and out_ready=0.

## Structure
- Package inversor_pkg:
  - mode_t enum: MODE_PASS=2'b00, MODE_NOT=2'b01, MODE_NEG=2'b10, MODE_ABS=2'b11.
  - occ_t enum: EMPTY, ONE, FULL.
- Sub-module inversor_lane: combinational, parameter WIDTH. Inputs are a_i, mode, and en (the mask bit); outputs are y_i and ovf_i. It is instantiated CHANNELS times via generate.
- The top level holds the FIFO, the occupancy FSM and the counter.

## Test plan
Benches use WIDTH=4 and CHANNELS=2; y={lane1,lane0}.
- Reset: rst=1 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, y=0, count=0; in_ready=1 in the first cycle after release.
- NOT: mode=01, mask=2'b11, a={4'b0011,4'b1010}, out_ready=1 -> next cycle y={4'b1100,4'b0101}, ovf=2'b00; count=1 after the transfer.
- NEG overflow: mode=10, mask=2'b11, a={4'b1000,4'b0001} -> y={4'b1000,4'b1111}, ovf=2'b10.
- ABS with mask: mode=11, mask=2'b01, a={4'b1110,4'b1101} -> y={4'b1110,4'b0011}, ovf=2'b00.
- Backpressure: out_ready=0, offer words W0, W1, W2 -> only W0 and W1 accepted, in_ready=0, y stable on W0. Then out_ready=1 -> W0, W1, W2 emerge in order on consecutive cycles, count=3.
- Saturation and reset mid-operation: CNT_WIDTH=3 with 9 transfers -> count=7. Then push 2 words, assert rst -> out_valid=0 and count=0 the next cycle, and the discarded words never appear.
